conv_tile_scheduler: RTL and testbench
======================================

// Module: conv_tile_scheduler
// PURPOSE
//  Sequences the shared bank of N_UNITS convolution units for one conv layer.
//  Each output row is split into two half-row tiles (column 0, then column N_UNITS).
//  Per tile it steps the receptive-field selector (row, column) and pulses the
//  units' clear line. It waits out the MAC latency, captures the unit results and
//  hands them to the output buffer over a valid/ready write port.
//  Start/busy/done face the layer-level control.
// PARAMETERS
//  DATA_WIDTH  16  width of one result pixel
//  D           1   filter depth
//  H           32  input image height
//  W           32  input image width
//  F           5   filter size
//  N_UNITS     (W-F+1)/2  conv units in the bank; (W-F+1) must be even (elaboration error otherwise)
//  MAC_CYCLES  D*F*F+2    cycles with clear low before unit results are valid
// PORTS
//  clk          in   1                   clock
//  reset        in   1                   synchronous, active-high reset
//  start        in   1                   begin one full layer pass; sampled only in IDLE
//  abort        in   1                   synchronous abandon of the current pass
//  busy         out  1                   high from the cycle after start is accepted until DONE
//  done         out  1                   1-cycle pulse when the last tile is accepted
//  row          out  6                   output row being computed (to receptive-field unit)
//  column       out  6                   0 or N_UNITS: half-row being computed
//  unit_clear   out  1                   reset/clear for all conv units (high = hold cleared)
//  unit_result  in   N_UNITS*DATA_WIDTH  concatenated conv-unit outputs, unit 0 in MSBs
//  wr_valid     out  1                   tile result available on wr_data
//  wr_ready     in   1                   output buffer accepts the tile this cycle
//  wr_addr      out  8                   tile index 0..TILES-1 (TILES = 2*(H-F+1)); row*2 + (column!=0)
//  wr_data      out  N_UNITS*DATA_WIDTH  captured tile result
// BEHAVIOUR
//  Reset values: busy=0, done=0, wr_valid=0, wr_addr=0, wr_data=0, row=0, column=0, unit_clear=1, state IDLE.
//  Registered outputs; no combinational path from any input to any output.
//  IDLE:
//   - unit_clear=1, busy=0.
//   - start=1 -> CLEAR, with row=0, column=0, wr_addr=0.
//  CLEAR (1 cycle):
//   - unit_clear=1; cycle counter cleared.
//   - -> ACCUM.
//  ACCUM (exactly MAC_CYCLES cycles):
//   - unit_clear=0; counter increments each cycle.
//   - Last cycle: capture unit_result into wr_data, then -> WRITE.
//  WRITE:
//   - wr_valid=1, unit_clear=1.
//   - wr_data and wr_addr are held stable until wr_valid && wr_ready.
//   - On accept: wr_valid drops next cycle, wr_addr increments.
//   - If column==0: column<=N_UNITS.
//   - Else: column<=0, row<=row+1.
//   - Last tile (row==H-F, column==N_UNITS) accepted -> DONE; otherwise -> CLEAR.
//   - wr_ready low stalls indefinitely with no state change.
//  DONE (1 cycle):
//   - done=1, busy=0; row, column, wr_addr return to 0.
//   - -> IDLE.
//  Timing, start accepted at cycle T with wr_ready tied high:
//   - tile k is presented (WRITE) at T+(MAC_CYCLES+2)*(k+1); defaults: 29k+29.
//   - done at T+(MAC_CYCLES+2)*TILES+1; defaults: T+1625.
//  start while busy: ignored, no effect.
//  abort=1 in any non-IDLE state: next cycle IDLE with reset values.
//   - No done pulse; no write accepted in that cycle, even if wr_ready=1.
//  reset overrides abort and start; reset mid-pass behaves like abort but also clears wr_data.
//  abort and start together in IDLE: abort wins, stay IDLE.
//  Tile counters never wrap within a pass; row never exceeds H-F.
// TESTING
//  1. Defaults, wr_ready=1, start at T -> 56 writes, addr 0..55; first wr_valid at T+29; done pulse at T+1625; busy low after.
//  2. Units stubbed to output unit index + tile*16 -> wr_data per addr matches; row/column sequence (0,0),(0,14),(1,0)...(27,14).
//  3. wr_ready low for 10 cycles on tile 3 -> wr_valid, wr_data, wr_addr=3 held stable; unit_clear stays 1; pass finishes 10 cycles later.
//  4. Second start pulse mid-pass (tile 20) -> ignored; done still at T+1625; exactly 56 writes.
//  5. abort during ACCUM of tile 10 -> next cycle IDLE: busy=0, wr_valid=0, row=0, unit_clear=1; no done; fresh start rescans from addr 0.
//  6. reset asserted during WRITE with wr_ready=1 -> no accept counted; all outputs at reset values next cycle.

Source files
------------

// File: rtl/conv_tile_scheduler_if.sv
// Write port from the tile scheduler to the output buffer: one tile result per
// valid/ready handshake, addressed by tile index.
interface conv_tile_scheduler_if #(
    parameter int N_UNITS    = 14,
    parameter int DATA_WIDTH = 16
);
    logic                          wr_valid;
    logic                          wr_ready;
    logic [7:0]                    wr_addr;
    logic [N_UNITS*DATA_WIDTH-1:0] wr_data;

    modport master (output wr_valid, output wr_addr, output wr_data, input wr_ready);
    modport slave  (input wr_valid, input wr_addr, input wr_data, output wr_ready);
endinterface

// File: rtl/conv_tile_scheduler.sv
// Walks one conv layer tile by tile: clear the unit bank, let it accumulate for
// MAC_CYCLES, capture the bank's results and hand them to the output buffer.
module conv_tile_scheduler #(
    parameter int DATA_WIDTH = 16,
    parameter int D          = 1,
    parameter int H          = 32,
    parameter int W          = 32,
    parameter int F          = 5,
    parameter int N_UNITS    = (W - F + 1) / 2,
    parameter int MAC_CYCLES = D * F * F + 2
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          start,
    input  logic                          abort,
    output logic                          busy,
    output logic                          done,
    output logic [5:0]                    row,
    output logic [5:0]                    column,
    output logic                          unit_clear,
    input  logic [N_UNITS*DATA_WIDTH-1:0] unit_result,
    conv_tile_scheduler_if.master         wr
);

    localparam int LAST_ROW = H - F;
    localparam int CW       = $clog2(MAC_CYCLES + 1);

    // Each output row is split evenly between two half-row tiles.
    generate
        if ((W - F + 1) % 2 != 0) begin : g_odd_row_width
            $error("conv_tile_scheduler: W-F+1 must be even");
        end
    endgenerate

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        ACCUM,
        WRITE,
        DONE
    } state_t;

    state_t                        state;
    state_t                        state_next;
    logic [CW-1:0]                 cnt;
    logic [7:0]                    addr;
    logic [N_UNITS*DATA_WIDTH-1:0] data;
    logic                          valid;
    logic                          accept;
    logic                          last_tile;

    assign wr.wr_valid = valid;
    assign wr.wr_addr  = addr;
    assign wr.wr_data  = data;

    // Abort beats everything except reset; an aborted WRITE does not count as accepted.
    always_comb begin
        state_next = state;
        accept     = 1'b0;
        last_tile  = (row == 6'(LAST_ROW)) && (column != 6'd0);
        case (state)
            IDLE:    if (start && !abort) state_next = CLEAR;
            CLEAR:   state_next = ACCUM;
            ACCUM:   if (cnt == CW'(MAC_CYCLES - 1)) state_next = WRITE;
            WRITE: begin
                if (wr.wr_ready) begin
                    accept     = 1'b1;
                    state_next = last_tile ? DONE : CLEAR;
                end
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
        if (abort && state != IDLE) begin
            state_next = IDLE;
            accept     = 1'b0;
        end
    end

    // Flags are registered from the next state so every output comes straight off a flop.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            cnt        <= '0;
            row        <= '0;
            column     <= '0;
            addr       <= '0;
            data       <= '0;
            valid      <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            unit_clear <= 1'b1;
        end else begin
            state      <= state_next;
            busy       <= (state_next == CLEAR) || (state_next == ACCUM) || (state_next == WRITE);
            done       <= (state_next == DONE);
            valid      <= (state_next == WRITE);
            unit_clear <= (state_next != ACCUM);
            if (abort && state != IDLE) begin
                row    <= '0;
                column <= '0;
                addr   <= '0;
                cnt    <= '0;
            end else begin
                case (state)
                    IDLE: begin
                        if (start) begin
                            row    <= '0;
                            column <= '0;
                            addr   <= '0;
                        end
                    end
                    CLEAR: cnt <= '0;
                    ACCUM: begin
                        cnt <= cnt + 1'b1;
                        if (state_next == WRITE) data <= unit_result;
                    end
                    WRITE: begin
                        if (accept) begin
                            if (last_tile) begin
                                row    <= '0;
                                column <= '0;
                                addr   <= '0;
                            end else begin
                                addr <= addr + 8'd1;
                                if (column == 6'd0) begin
                                    column <= 6'(N_UNITS);
                                end else begin
                                    column <= '0;
                                    row    <= row + 6'd1;
                                end
                            end
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_conv_tile_scheduler.sv
// Drives full layer passes through conv_tile_scheduler with stubbed conv units and
// compares every presented tile and the pass timing against a tile-level model.
module tb_conv_tile_scheduler;

    localparam int NU    = 14;
    localparam int DW    = 16;
    localparam int PER   = 29;
    localparam int TILES = 56;

    logic          clk;
    logic          reset;
    logic          start;
    logic          abort;
    logic          busy;
    logic          done;
    logic [5:0]    row;
    logic [5:0]    column;
    logic          unit_clear;
    logic [NU*DW-1:0] unit_result;
    logic [15:0]   offs;
    int            total;
    int            bad;
    int            dc;
    int            dn;

    conv_tile_scheduler_if #(.N_UNITS(NU), .DATA_WIDTH(DW)) wr_if ();

    conv_tile_scheduler dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .abort       (abort),
        .busy        (busy),
        .done        (done),
        .row         (row),
        .column      (column),
        .unit_clear  (unit_clear),
        .unit_result (unit_result),
        .wr          (wr_if.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Unit u of the stub reports u + tile*16 + a per-pass random offset, unit 0 in the MSBs.
    function automatic logic [NU*DW-1:0] tileData(input int k, input logic [15:0] o);
        logic [NU*DW-1:0] r;
        r = '0;
        for (int u = 0; u < NU; u++) r[(NU-1-u)*DW +: DW] = DW'(u + k * 16 + int'(o));
        return r;
    endfunction

    always_comb unit_result = tileData(int'(row) * 2 + ((column != 6'd0) ? 1 : 0), offs);

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [255:0] obs, input logic [255:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // One pass started in the current (idle) cycle. Each tile is presented PER cycles
    // after the previous one was accepted; done follows the last accept by one cycle.
    task automatic applyStimulus(input int stallTile, input int stallLen, input bit randReady,
                                 input int restartCycle, input int abortCycle, input int resetTile,
                                 output int doneCycle);
        int k, expPresent, lastAccept, stallLeft;
        bit presenting, finished;
        k = 0; expPresent = PER; lastAccept = 0; stallLeft = 0;
        presenting = 0; finished = 0; doneCycle = -1;
        offs = 16'($urandom_range(0, 255));
        start = 1'b1;
        wr_if.wr_ready = 1'b1;
        for (int c = 1; c <= 6000 && !finished; c++) begin
            tick();
            start = (c == restartCycle);
            if (c == 1) begin
                checkOutput("clear_phase", unit_clear, 1);
                checkOutput("clear_no_valid", wr_if.wr_valid, 0);
            end
            if (c == 2) checkOutput("accum_phase", unit_clear, 0);
            if (c == abortCycle) begin
                abort = 1'b1;
                tick();
                abort = 1'b0;
                checkOutput("abort_busy", busy, 0);
                checkOutput("abort_done", done, 0);
                checkOutput("abort_valid", wr_if.wr_valid, 0);
                checkOutput("abort_row", row, 0);
                checkOutput("abort_column", column, 0);
                checkOutput("abort_addr", wr_if.wr_addr, 0);
                checkOutput("abort_clear", unit_clear, 1);
                return;
            end
            if (done) begin
                checkOutput("done_time", c, lastAccept + 1);
                checkOutput("done_busy", busy, 0);
                checkOutput("write_count", k, TILES);
                doneCycle = c;
                finished = 1;
            end else begin
                checkOutput("busy_run", busy, 1);
                if (wr_if.wr_valid) begin
                    if (!presenting) begin
                        checkOutput("present_time", c, expPresent);
                        presenting = 1;
                        stallLeft = (k == stallTile) ? stallLen : 0;
                    end
                    checkOutput("wr_addr", wr_if.wr_addr, k);
                    checkOutput("wr_data", wr_if.wr_data, tileData(k, offs));
                    checkOutput("row", row, k / 2);
                    checkOutput("column", column, (k % 2 != 0) ? NU : 0);
                    checkOutput("write_clear", unit_clear, 1);
                    if (k == resetTile) begin
                        wr_if.wr_ready = 1'b1;
                        reset = 1'b1;
                        tick();
                        reset = 1'b0;
                        checkOutput("rst_busy", busy, 0);
                        checkOutput("rst_done", done, 0);
                        checkOutput("rst_valid", wr_if.wr_valid, 0);
                        checkOutput("rst_addr", wr_if.wr_addr, 0);
                        checkOutput("rst_data", wr_if.wr_data, 0);
                        checkOutput("rst_row", row, 0);
                        checkOutput("rst_column", column, 0);
                        checkOutput("rst_clear", unit_clear, 1);
                        return;
                    end
                    if (stallLeft > 0) begin
                        wr_if.wr_ready = 1'b0;
                        stallLeft--;
                    end else begin
                        wr_if.wr_ready = randReady ? ($urandom_range(0, 2) != 0) : 1'b1;
                    end
                    if (wr_if.wr_ready) begin
                        k++;
                        presenting = 0;
                        lastAccept = c;
                        expPresent = c + PER;
                    end
                end else begin
                    if (presenting) checkOutput("valid_held", wr_if.wr_valid, 1);
                    wr_if.wr_ready = randReady ? ($urandom_range(0, 1) != 0) : 1'b1;
                end
            end
        end
        if (!finished) checkOutput("pass_timeout", finished, 1);
    endtask

    initial begin
        total = 0; bad = 0;
        reset = 1'b1; start = 1'b0; abort = 1'b0; offs = '0;
        wr_if.wr_ready = 1'b0;
        repeat (3) tick();
        checkOutput("reset_busy", busy, 0);
        checkOutput("reset_done", done, 0);
        checkOutput("reset_valid", wr_if.wr_valid, 0);
        checkOutput("reset_addr", wr_if.wr_addr, 0);
        checkOutput("reset_data", wr_if.wr_data, 0);
        checkOutput("reset_row", row, 0);
        checkOutput("reset_column", column, 0);
        checkOutput("reset_clear", unit_clear, 1);
        reset = 1'b0;
        tick();

        // Abort and start together while idle: abort wins.
        start = 1'b1; abort = 1'b1;
        tick();
        start = 1'b0; abort = 1'b0;
        tick();
        checkOutput("idle_abort_start_busy", busy, 0);
        checkOutput("idle_abort_start_clear", unit_clear, 1);

        $display("[TB] plain pass with a stray start during tile 20");
        applyStimulus(-1, 0, 1'b0, PER * 20 + 5, -1, -1, dc);
        checkOutput("done_cycle_plain", dc, 1625);
        tick();
        checkOutput("post_busy", busy, 0);
        checkOutput("post_done", done, 0);
        checkOutput("post_row", row, 0);
        checkOutput("post_column", column, 0);
        checkOutput("post_addr", wr_if.wr_addr, 0);

        $display("[TB] pass with a 10-cycle stall on tile 3");
        applyStimulus(3, 10, 1'b0, -1, -1, -1, dc);
        checkOutput("done_cycle_stall", dc, 1635);
        tick();

        $display("[TB] abort during accumulation of tile 10");
        applyStimulus(-1, 0, 1'b0, -1, 300, -1, dc);
        dn = 0;
        repeat (40) begin
            tick();
            if (done) dn++;
        end
        checkOutput("no_done_after_abort", dn, 0);
        checkOutput("idle_after_abort", busy, 0);

        $display("[TB] fresh pass with random wr_ready");
        applyStimulus(-1, 0, 1'b1, -1, -1, -1, dc);
        tick();

        $display("[TB] reset during write of tile 5");
        applyStimulus(-1, 0, 1'b0, -1, -1, 5, dc);
        tick();

        $display("[TB] pass with random wr_ready after reset");
        applyStimulus(-1, 0, 1'b1, -1, -1, -1, dc);
        tick();
        checkOutput("final_busy", busy, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
